md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Parametrised iterative multiply/divide unit implementing the RV32M/RV64M operations.
- Generalises the single-cycle integer ALU to multi-cycle arithmetic with width and throughput parameters.
- Sits in the execute stage beside the ALU. Valid/ready handshakes let the pipeline stall while it runs.
- Carries the destination register tag through to writeback.

Parameters:
XLEN, 32, operand/result width in bits; 32 or 64.
UNROLL, 1, quotient/product bits resolved per cycle; one of 1, 2, 4; must divide XLEN.

Ports:
clk  input  1  clock; all state changes on its rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  pipeline flush; discards any in-flight operation
in_valid  input  1  operation request
in_ready  output  1  unit can accept a request
in_op  input  3  md_op_t operation code (RISC-V funct3 encoding)
in_a  input  XLEN  source 1 (multiplicand/dividend)
in_b  input  XLEN  source 2 (multiplier/divisor)
in_rd  input  5  destination register tag
out_valid  output  1  result available
out_ready  input  1  consumer accepts the result
out_result  output  XLEN  result
out_rd  output  5  tag of the operation that produced out_result

Behaviour:
- Reset: asynchronous on rst_n low. State goes to IDLE; in_ready=1, out_valid=0, out_result=0, out_rd=0.
- Reset mid-operation abandons the operation with no output.
- States:
  - IDLE: in_ready=1. in_valid&in_ready accepts the request (cycle T) and latches op, operands and rd. A special case goes to DONE; otherwise to CALC.
  - CALC: N=XLEN/UNROLL iterations, counter N-1 down to 0. At counter 0, apply sign correction and go to DONE.
  - DONE: out_valid=1; out_result/out_rd held stable. out_valid&out_ready returns the unit to IDLE next cycle.
- Latency:
  - Normal operations: out_valid first high at T+N+1 (T+33 for XLEN=32, UNROLL=1).
  - Special cases: out_valid at T+1.
- Throughput: in_ready is high only in IDLE. There is no accept in the same cycle as the output handshake.
- Ops (md_op_t):
  - MUL=000: low XLEN bits of the product.
  - MULH=001: high half, signed×signed.
  - MULHSU=010: high half, signed a × unsigned b.
  - MULHU=011: high half, unsigned×unsigned.
  - DIV=100 / DIVU=101: quotient, truncated toward zero.
  - REM=110 / REMU=111: remainder; sign follows the dividend.
- Arithmetic:
  - Signed operands are converted to magnitudes at accept; the unsigned iteration runs on the magnitudes.
  - The final negation is applied on the CALC→DONE transition.
  - Multiply keeps a 2*XLEN product register.
  - Divide uses restoring division, UNROLL bits per cycle.
- Special cases (resolved at accept, straight to DONE):
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give in_a.
  - Signed overflow (a=most negative, b=-1): DIV gives in_a; REM gives 0.
  - No other operands are special-cased; zero operands run the full N cycles for deterministic latency.
- Flush:
  - In any state, the unit is in IDLE the next cycle with out_valid=0 and the result discarded.
  - flush with in_valid in the same cycle: flush wins and nothing is accepted.
  - flush with out_valid&out_ready in the same cycle: the handshake counts as completed, and the unit goes to IDLE.
- Illegal UNROLL is caught by an elaboration-time assertion.

Decomposition:
- Package md_pkg holds md_op_t (3-bit enum above), md_state_t (IDLE, CALC, DONE), and helper functions is_div(op), is_signed_a(op), is_signed_b(op).
- One sub-module is natural: md_step, a combinational UNROLL-bit iteration stage (shift-add or restoring-subtract) instantiated once.
- md_unit keeps the FSM, counter, operand registers and sign fix-up.

Test Plan:
- Reset/idle: rst_n low mid-CALC, then release → in_ready=1, out_valid=0, out_result=0; no result for the abandoned op.
- Multiply (XLEN=32, UNROLL=1): MUL 7×0xFFFFFFFD → 0xFFFFFFEB, out_valid exactly at T+33.
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- Divide: DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM 0xFFFFFFF9/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases:
  - DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each with out_valid at T+1.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- Backpressure/tag: out_ready low 5 cycles after out_valid → out_result/out_rd (rd=13) stable and in_ready=0. out_ready high → in_ready=1 next cycle, and a back-to-back op is accepted.
- Flush and parameters: flush at T+10 → no out_valid, in_ready=1 at T+11. Rerun the MUL/DIV vectors with UNROLL=4 (out_valid at T+9) and with XLEN=64 (UNROLL=1).

Source files
------------

// File: rtl/md_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package md_pkg;

  // Operation codes follow the RISC-V M-extension funct3 encoding.
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

  // Divide and remainder share funct3[2] = 1.
  function automatic logic is_div(input md_op_t op);
    return op[2];
  endfunction

  // Source 1 is treated as signed by MULH, MULHSU, DIV and REM.
  function automatic logic is_signed_a(input md_op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Source 2 is treated as signed by MULH, DIV and REM.
  function automatic logic is_signed_b(input md_op_t op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/md_unit_step.sv
// Combinational iteration stage: UNROLL shift-add (multiply) or
// restoring-subtract (divide) steps on the {hi, lo} working pair.
//   multiply: {hi, lo} is the product register, lo starts as the multiplier,
//             i_opnd is the multiplicand; each step adds then shifts right.
//   divide:   hi is the partial remainder, lo starts as the dividend and
//             fills with quotient bits from the right; i_opnd is the divisor.
module md_step #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_opnd,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN-1:0] w_hi;
  logic [XLEN-1:0] w_lo;
  logic [XLEN:0]   w_sh;
  logic [XLEN:0]   w_diff;
  logic [XLEN:0]   w_sum;

  // Chain UNROLL single-bit steps; the remainder stays below the divisor so
  // the XLEN+1 bit subtraction borrow (bit XLEN) is the restore decision.
  always_comb begin
    w_hi   = i_hi;
    w_lo   = i_lo;
    w_sh   = '0;
    w_diff = '0;
    w_sum  = '0;
    for (int k = 0; k < UNROLL; k++) begin
      if (i_is_div) begin
        w_sh   = {w_hi, w_lo[XLEN-1]};
        w_diff = w_sh - {1'b0, i_opnd};
        if (!w_diff[XLEN]) begin
          w_hi = w_diff[XLEN-1:0];
          w_lo = {w_lo[XLEN-2:0], 1'b1};
        end else begin
          w_hi = w_sh[XLEN-1:0];
          w_lo = {w_lo[XLEN-2:0], 1'b0};
        end
      end else begin
        w_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, i_opnd} : {(XLEN+1){1'b0}});
        w_hi  = w_sum[XLEN:1];
        w_lo  = {w_sum[0], w_lo[XLEN-1:1]};
      end
    end
  end

  assign o_hi = w_hi;
  assign o_lo = w_lo;

endmodule

// File: rtl/md_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the execute stage.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; in_ready is high only in IDLE, out_valid only in DONE, and the
// result and tag stay stable while out_valid is high and out_ready is low.
module md_unit
  import md_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic [1:0]      o_dbg_state
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // Reject unsupported widths and unroll factors at elaboration.
  if (!((XLEN == 32) || (XLEN == 64)) || !((UNROLL == 1) || (UNROLL == 2) || (UNROLL == 4))
      || ((XLEN % UNROLL) != 0)) begin : g_bad_param
    $error("md_unit: illegal XLEN/UNROLL combination");
  end

  md_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  md_op_t          r_op;
  logic            r_neg;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_opnd;
  logic [4:0]      r_tag;
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_rd;

  md_op_t          w_op;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic            w_neg;
  logic [XLEN-1:0] w_step_hi;
  logic [XLEN-1:0] w_step_lo;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0] w_quo_fix;
  logic [XLEN-1:0] w_rem_fix;
  logic [XLEN-1:0] w_final;

  // Decode the request: operand magnitudes, result sign and special cases.
  always_comb begin
    w_op          = md_op_t'(in_op);
    w_a_neg       = is_signed_a(w_op) && in_a[XLEN-1];
    w_b_neg       = is_signed_b(w_op) && in_b[XLEN-1];
    w_a_mag       = w_a_neg ? (~in_a + 1'b1) : in_a;
    w_b_mag       = w_b_neg ? (~in_b + 1'b1) : in_b;
    w_div_zero    = is_div(w_op) && (in_b == '0);
    w_ovf         = ((w_op == OP_DIV) || (w_op == OP_REM)) && (in_a == MIN_NEG) && (in_b == '1);
    w_special     = w_div_zero || w_ovf;
    w_special_res = '0;
    if (w_div_zero) begin
      w_special_res = w_op[1] ? in_a : '1;
    end else if (w_ovf) begin
      w_special_res = (w_op == OP_DIV) ? in_a : '0;
    end
    // Remainder takes the dividend's sign; everything else the xor of signs.
    w_neg = (is_div(w_op) && w_op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
  end

  md_step #(
    .XLEN   (XLEN),
    .UNROLL (UNROLL)
  ) u_step (
    .i_is_div (is_div(r_op)),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .i_opnd   (r_opnd),
    .o_hi     (w_step_hi),
    .o_lo     (w_step_lo)
  );

  // Sign fix-up and result selection from the final iteration's output.
  always_comb begin
    w_prod     = {w_step_hi, w_step_lo};
    w_prod_fix = r_neg ? (~w_prod + 1'b1) : w_prod;
    w_quo_fix  = r_neg ? (~w_step_lo + 1'b1) : w_step_lo;
    w_rem_fix  = r_neg ? (~w_step_hi + 1'b1) : w_step_hi;
    w_final    = '0;
    case (r_op)
      OP_MUL:                       w_final = w_prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_final = w_quo_fix;
      OP_REM, OP_REMU:              w_final = w_rem_fix;
      default:                      w_final = '0;
    endcase
  end

  // Main FSM: accept in IDLE, iterate in CALC, hold the result in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_op     <= OP_MUL;
      r_neg    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_tag    <= '0;
      r_result <= '0;
      r_rd     <= '0;
    end else if (flush) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op  <= w_op;
            r_neg <= w_neg;
            r_tag <= in_rd;
            r_hi  <= '0;
            r_cnt <= CW'(N - 1);
            if (is_div(w_op)) begin
              r_lo   <= w_a_mag;
              r_opnd <= w_b_mag;
            end else begin
              r_lo   <= w_b_mag;
              r_opnd <= w_a_mag;
            end
            if (w_special) begin
              r_result <= w_special_res;
              r_rd     <= in_rd;
              r_state  <= ST_DONE;
            end else begin
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          r_hi  <= w_step_hi;
          r_lo  <= w_step_lo;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_result <= w_final;
            r_rd     <= r_tag;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == ST_IDLE);
  assign out_valid   = (r_state == ST_DONE);
  assign out_result  = r_result;
  assign out_rd      = r_rd;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: three instances cover XLEN=32/UNROLL=1,
// XLEN=32/UNROLL=4 and XLEN=64/UNROLL=1.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        out_ready;
  logic [2:0]  op;
  logic [63:0] a;
  logic [63:0] b;
  logic [4:0]  rd;
  logic        v0, v1, v2;
  logic        ir0, ir1, ir2;
  logic        ov0, ov1, ov2;
  logic [31:0] res0, res1;
  logic [63:0] res2;
  logic [4:0]  ord0, ord1, ord2;
  logic [1:0]  st0, st1, st2;

  int total = 0;
  int bad   = 0;

  // Clock
  always #5 clk = ~clk;

  md_unit #(.XLEN(32), .UNROLL(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(v0), .in_ready(ir0),
    .in_op(op), .in_a(a[31:0]), .in_b(b[31:0]), .in_rd(rd), .out_valid(ov0),
    .out_ready(out_ready), .out_result(res0), .out_rd(ord0), .o_dbg_state(st0)
  );

  md_unit #(.XLEN(32), .UNROLL(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(v1), .in_ready(ir1),
    .in_op(op), .in_a(a[31:0]), .in_b(b[31:0]), .in_rd(rd), .out_valid(ov1),
    .out_ready(out_ready), .out_result(res1), .out_rd(ord1), .o_dbg_state(st1)
  );

  md_unit #(.XLEN(64), .UNROLL(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(v2), .in_ready(ir2),
    .in_op(op), .in_a(a), .in_b(b), .in_rd(rd), .out_valid(ov2),
    .out_ready(out_ready), .out_result(res2), .out_rd(ord2), .o_dbg_state(st2)
  );

  function automatic logic get_ir(input int k);
    return (k == 0) ? ir0 : (k == 1) ? ir1 : ir2;
  endfunction

  function automatic logic get_ov(input int k);
    return (k == 0) ? ov0 : (k == 1) ? ov1 : ov2;
  endfunction

  function automatic logic [63:0] get_res(input int k);
    return (k == 0) ? {32'h0, res0} : (k == 1) ? {32'h0, res1} : res2;
  endfunction

  function automatic logic [4:0] get_rd(input int k);
    return (k == 0) ? ord0 : (k == 1) ? ord1 : ord2;
  endfunction

  task automatic set_valid(input int k, input logic v);
    if (k == 0) v0 = v;
    else if (k == 1) v1 = v;
    else v2 = v;
  endtask

  // Driver: one operation through instance k, checking result, tag and latency.
  task automatic run(input int k, input logic [2:0] o, input logic [63:0] aa,
                     input logic [63:0] bb, input logic [4:0] t,
                     input logic [63:0] exp, input int lat, input string nm);
    int cyc;
    op = o; a = aa; b = bb; rd = t;
    total++;
    if (get_ir(k) !== 1'b1) begin
      bad++;
      $display("FAIL %s in_ready_before_accept act=%b exp=1", nm, get_ir(k));
    end
    set_valid(k, 1'b1);
    @(posedge clk); #1;
    set_valid(k, 1'b0);
    cyc = 1;
    while (get_ov(k) !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (cyc != lat) begin
      bad++;
      $display("FAIL %s latency act=%0d exp=%0d", nm, cyc, lat);
    end
    total++;
    if (get_res(k) !== exp) begin
      bad++;
      $display("FAIL %s result act=%h exp=%h", nm, get_res(k), exp);
    end
    total++;
    if (get_rd(k) !== t) begin
      bad++;
      $display("FAIL %s rd act=%0d exp=%0d", nm, get_rd(k), t);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic seen;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    op = 3'b000; a = '0; b = '0; rd = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL reset_in_ready act=%b exp=1", ir0); end
    total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL reset_out_valid act=%b exp=0", ov0); end
    total++; if (res0 !== 32'h0) begin bad++; $display("FAIL reset_result act=%h exp=0", res0); end
    total++; if (ord0 !== 5'd0) begin bad++; $display("FAIL reset_rd act=%0d exp=0", ord0); end
    // Start a multiply, then pull reset in the middle of CALC.
    op = 3'b000; a = 64'd7; b = 64'd9; rd = 5'd4;
    v0 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL midreset_in_ready act=%b exp=1", ir0); end
    total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL midreset_out_valid act=%b exp=0", ov0); end
    total++; if (res0 !== 32'h0) begin bad++; $display("FAIL midreset_result act=%h exp=0", res0); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ov0 === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midreset_no_output act=%b exp=0", seen); end
  endtask

  task automatic test_mul();
    run(0, 3'b000, 64'h7,        64'hFFFFFFFD, 5'd1, 64'hFFFFFFEB, 33, "mul");
    run(0, 3'b001, 64'h80000000, 64'h80000000, 5'd2, 64'h40000000, 33, "mulh");
    run(0, 3'b011, 64'hFFFFFFFF, 64'hFFFFFFFF, 5'd3, 64'hFFFFFFFE, 33, "mulhu");
    run(0, 3'b010, 64'hFFFFFFFF, 64'h2,        5'd4, 64'hFFFFFFFF, 33, "mulhsu");
  endtask

  task automatic test_div();
    run(0, 3'b100, 64'hFFFFFFF9, 64'h2, 5'd5, 64'hFFFFFFFD, 33, "div");
    run(0, 3'b110, 64'hFFFFFFF9, 64'h2, 5'd6, 64'hFFFFFFFF, 33, "rem");
    run(0, 3'b101, 64'd100,      64'd7, 5'd7, 64'd14,       33, "divu");
    run(0, 3'b111, 64'd100,      64'd7, 5'd8, 64'd2,        33, "remu");
  endtask

  task automatic test_special();
    run(0, 3'b100, 64'd5,        64'd0,        5'd9,  64'hFFFFFFFF, 1, "div_by_zero");
    run(0, 3'b110, 64'd5,        64'd0,        5'd10, 64'd5,        1, "rem_by_zero");
    run(0, 3'b100, 64'h80000000, 64'hFFFFFFFF, 5'd11, 64'h80000000, 1, "div_ovf");
    run(0, 3'b110, 64'h80000000, 64'hFFFFFFFF, 5'd12, 64'h0,        1, "rem_ovf");
  endtask

  task automatic test_back_to_back();
    int cyc;
    out_ready = 1'b0;
    op = 3'b000; a = 64'd3; b = 64'd5; rd = 5'd13;
    v0 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0;
    cyc = 1;
    while (ov0 !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    total++; if (cyc != 33) begin bad++; $display("FAIL bp_latency act=%0d exp=33", cyc); end
    for (int i = 0; i < 5; i++) begin
      total++; if (res0 !== 32'd15) begin bad++; $display("FAIL bp_result cyc%0d act=%h exp=f", i, res0); end
      total++; if (ord0 !== 5'd13) begin bad++; $display("FAIL bp_rd cyc%0d act=%0d exp=13", i, ord0); end
      total++; if (ir0 !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc%0d act=%b exp=0", i, ir0); end
      total++; if (ov0 !== 1'b1) begin bad++; $display("FAIL bp_out_valid cyc%0d act=%b exp=1", i, ov0); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready act=%b exp=1", ir0); end
    total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL bp_release_out_valid act=%b exp=0", ov0); end
    run(0, 3'b101, 64'd100, 64'd7, 5'd2, 64'd14, 33, "back_to_back");
  endtask

  task automatic test_flush();
    logic seen;
    // Flush during CALC at T+10.
    op = 3'b101; a = 64'd100; b = 64'd7; rd = 5'd20;
    v0 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL flush_calc_in_ready act=%b exp=1", ir0); end
    total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL flush_calc_out_valid act=%b exp=0", ov0); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ov0 === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_calc_no_output act=%b exp=0", seen); end
    // Flush together with a request: nothing is accepted.
    flush = 1'b1; v0 = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; v0 = 1'b0;
    total++; if (st0 !== 2'd0) begin bad++; $display("FAIL flush_accept_state act=%0d exp=0", st0); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ov0 === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_accept_no_output act=%b exp=0", seen); end
    // Flush while a result is waiting in DONE.
    out_ready = 1'b0;
    op = 3'b100; a = 64'd5; b = 64'd0; rd = 5'd21;
    v0 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0;
    total++; if (ov0 !== 1'b1) begin bad++; $display("FAIL flush_done_setup act=%b exp=1", ov0); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    out_ready = 1'b1;
    total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL flush_done_out_valid act=%b exp=0", ov0); end
    total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL flush_done_in_ready act=%b exp=1", ir0); end
  endtask

  task automatic test_params();
    run(1, 3'b000, 64'h7,        64'hFFFFFFFD, 5'd1, 64'hFFFFFFEB, 9, "u4_mul");
    run(1, 3'b001, 64'h80000000, 64'h80000000, 5'd2, 64'h40000000, 9, "u4_mulh");
    run(1, 3'b100, 64'hFFFFFFF9, 64'h2,        5'd3, 64'hFFFFFFFD, 9, "u4_div");
    run(1, 3'b111, 64'd100,      64'd7,        5'd4, 64'd2,        9, "u4_remu");
    run(2, 3'b000, 64'h7, 64'hFFFFFFFFFFFFFFFD, 5'd5, 64'hFFFFFFFFFFFFFFEB, 65, "x64_mul");
    run(2, 3'b011, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd6,
        64'hFFFFFFFFFFFFFFFE, 65, "x64_mulhu");
    run(2, 3'b100, 64'hFFFFFFFFFFFFFFF9, 64'h2, 5'd7, 64'hFFFFFFFFFFFFFFFD, 65, "x64_div");
    run(2, 3'b110, 64'hFFFFFFFFFFFFFFF9, 64'h2, 5'd8, 64'hFFFFFFFFFFFFFFFF, 65, "x64_rem");
    run(2, 3'b101, 64'd100, 64'd7, 5'd9, 64'd14, 65, "x64_divu");
    run(2, 3'b100, 64'd5, 64'd0, 5'd10, 64'hFFFFFFFFFFFFFFFF, 1, "x64_div_by_zero");
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_back_to_back();
    test_flush();
    test_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
